intra_chroma_mode_bin_serializer: RTL and testbench
===================================================

Name: intra_chroma_mode_bin_serializer

Overview:
Parametrised successor to the single-mode chroma intra-mode binariser. It accepts one record per CU carrying 1..MAX_MODES chroma intra modes (4:4:4 NxN carries 4), buffers the records in a small FIFO, and serialises the HEVC intra_chroma_pred_mode bins one per cycle. Bins leave on a valid/ready stream, each tagged context-coded or bypass and marked at the CU's last bin. It sits between the CU syntax front end and the CABAC arithmetic engine.

Parameters:
MAX_MODES, 4, maximum chroma modes per CU record (at least 1)
FIFO_DEPTH, 4, CU-record FIFO depth (power of two, at least 2)
CNT_W, 16, width of the emitted-bin counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  CU record valid
in_ready  out  1  FIFO can accept a record
in_num_modes  in  $clog2(MAX_MODES+1)  number of modes in the record (legal range 1..MAX_MODES)
in_modes  in  MAX_MODES*3  packed modes; mode k occupies bits [3k+2:3k]; 0=PLANAR, 1=ANG26, 2=ANG10, 3=DC, 4=DM
bin_valid  out  1  output bin valid
bin_ready  in  1  downstream accepts the bin
bin_val  out  1  bin value
bin_bypass  out  1  1 = bypass bin, 0 = context-coded bin (ctxInc 0)
bin_last  out  1  last bin of the current CU record
bin_count  out  CNT_W  count of accepted bins, wraps modulo 2^CNT_W
err_illegal  out  1  sticky flag: illegal mode or illegal mode count seen

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: bin_valid=0, bin_val=0, bin_bypass=0, bin_last=0, bin_count=0, err_illegal=0, FIFO empty, FSM in IDLE. in_ready=1 after reset is released.
- Reset asserted mid-CU: the partial CU is discarded with no further bins, and the FIFO is flushed.
- in_ready = !fifo_full. A push happens when in_valid && in_ready. There is no push-through when full, even if a pop occurs on the same edge.
- Binarisation of each mode, in index order 0..n-1:
  - DM (4): a single context-coded bin of value 0.
  - Explicit mode m (0..3): a context-coded 1, then bypass bit m[1], then bypass bit m[0].
- Illegal inputs:
  - Mode 5..7 is coded as DM, and err_illegal is set.
  - in_num_modes of 0 or greater than MAX_MODES is treated as 1, and err_illegal is set.
  - err_illegal clears only on rst.
- FSM states and transitions:
  - IDLE: on the edge where the FIFO is non-empty, pop one record, latch it, set mode index to 0, go to PREFIX.
  - PREFIX: present the prefix bin. When it is accepted: for DM go to NEXT_MODE; otherwise go to SUF1.
  - SUF1: present the bypass bin m[1]. When accepted, go to SUF0.
  - SUF0: present the bypass bin m[0]. When accepted, go to NEXT_MODE.
  - NEXT_MODE is a decision on the same edge, not a separate cycle:
    - If index < n-1: increment index, go to PREFIX.
    - Else if the FIFO is non-empty: pop the next record, go to PREFIX.
    - Else: go to IDLE.
- Latency and throughput:
  - A record pushed at edge E into an empty FIFO with the FSM in IDLE gives bin_valid high after edge E+1.
  - With bin_ready held high, the block sustains 1 bin per cycle with no bubbles between modes or between back-to-back CUs.
- Output stability: outputs are registered. While bin_valid && !bin_ready, bin_val, bin_bypass and bin_last hold stable.
- bin_last is 1 only on the final bin of the final mode of a record.
- bin_count increments on every edge where bin_valid && bin_ready.
- Bins per CU = sum over modes of (DM ? 1 : 3). The maximum is 3*MAX_MODES.

Decomposition:
- Package chroma_bin_pkg:
  - Mode localparams: INTRA_PLANAR=0, INTRA_ANG26=1, INTRA_ANG10=2, INTRA_DC=3, DM_CHROMA_IDX=4, CHROMA_MODE_W=3.
  - FSM enum ser_state_t {IDLE, PREFIX, SUF1, SUF0}.
  - Record struct typedef.
- One sub-module: cu_rec_fifo, a parametrised synchronous FIFO with async active-high reset exposing full and empty. The serialiser FSM lives in the top module.

Test Plan:
- Single-mode record {n=1, mode=4}, bin_ready=1 -> one bin: val=0, bypass=0, last=1 one cycle after the push; bin_count=1.
- {n=1, mode=2} -> bins (1,ctx), (1,byp), (0,byp, last=1) on consecutive cycles; bin_count=3.
- {n=4, modes=[4,0,3,1]} -> 10 bins: 0c | 1c,0b,0b | 1c,1b,1b | 1c,0b,1b. Only the 10th bin has last=1. No gap cycles.
- Backpressure: bin_ready toggled 1,0,0,1,... on mode 3 -> each bin is held stable while stalled, the sequence is unchanged, and bin_count counts only handshakes.
- FIFO full: 4 records pushed with bin_ready=0 -> in_ready=0 after the 4th push, the 5th in_valid is not accepted. Releasing bin_ready drains all CUs back-to-back with no inter-CU bubble, and in_ready re-asserts after the first pop.
- Illegal mode and reset: {n=1, mode=6} gives the DM bin 0 with err_illegal=1 sticky. Asserting rst mid-CU after 2 of 3 bins -> bin_valid=0 immediately and no remaining bins, bin_count=0, err_illegal=0, FIFO empty.

Source files
------------

// File: rtl/chroma_bin_pkg.sv
// Shared types for the chroma intra-mode bin serialiser: mode codes, FSM states
// and the decoded per-mode record.
package chroma_bin_pkg;

  localparam int CHROMA_MODE_W = 3;

  localparam logic [CHROMA_MODE_W-1:0] INTRA_PLANAR  = 3'd0;
  localparam logic [CHROMA_MODE_W-1:0] INTRA_ANG26   = 3'd1;
  localparam logic [CHROMA_MODE_W-1:0] INTRA_ANG10   = 3'd2;
  localparam logic [CHROMA_MODE_W-1:0] INTRA_DC      = 3'd3;
  localparam logic [CHROMA_MODE_W-1:0] DM_CHROMA_IDX = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUF1   = 2'd2,
    SUF0   = 2'd3
  } ser_state_t;

  // One chroma mode after decoding: DM flag plus the 2-bit explicit index.
  typedef struct packed {
    logic       is_dm;
    logic [1:0] m;
  } chroma_mode_rec_t;

  // Codes 5..7 are not legal modes; they are coded as DM.
  function automatic logic mode_is_dm(input logic [CHROMA_MODE_W-1:0] code);
    return code >= DM_CHROMA_IDX;
  endfunction

  function automatic logic mode_illegal(input logic [CHROMA_MODE_W-1:0] code);
    return code > DM_CHROMA_IDX;
  endfunction

  function automatic chroma_mode_rec_t decode_mode(input logic [CHROMA_MODE_W-1:0] code);
    chroma_mode_rec_t r;
    r.is_dm = mode_is_dm(code);
    r.m     = code[1:0];
    return r;
  endfunction

endpackage

// File: rtl/cu_rec_fifo.sv
// Small synchronous FIFO for CU records. Pushes while full and pops while empty
// are ignored; read data is the head entry, valid whenever empty is low.
module cu_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/intra_chroma_mode_bin_serializer.sv
// Buffers CU records of 1..MAX_MODES chroma intra modes and emits the
// intra_chroma_pred_mode bins one per cycle towards the CABAC engine.
module intra_chroma_mode_bin_serializer
  import chroma_bin_pkg::*;
#(
  parameter int MAX_MODES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [$clog2(MAX_MODES+1)-1:0]      in_num_modes,
  input  logic [MAX_MODES*CHROMA_MODE_W-1:0]  in_modes,
  output logic                                bin_valid,
  input  logic                                bin_ready,
  output logic                                bin_val,
  output logic                                bin_bypass,
  output logic                                bin_last,
  output logic [CNT_W-1:0]                    bin_count,
  output logic                                err_illegal
);

  localparam int NW = $clog2(MAX_MODES+1);
  localparam int MW = MAX_MODES*CHROMA_MODE_W;
  localparam int RW = NW + MW;

  function automatic logic [CHROMA_MODE_W-1:0] pick_mode(input logic [MW-1:0] modes,
                                                         input logic [NW-1:0] i);
    logic [CHROMA_MODE_W-1:0] code;
    code = '0;
    for (int k = 0; k < MAX_MODES; k++)
      if (i == NW'(k)) code = modes[k*CHROMA_MODE_W +: CHROMA_MODE_W];
    return code;
  endfunction

  // ---------------- record intake ----------------
  logic          push;
  logic          push_illegal;
  logic [NW-1:0] n_eff;
  logic          fifo_full;
  logic          fifo_empty;
  logic          load;
  logic [RW-1:0] fifo_rdata;

  // Both streams transfer on a clock edge where valid and ready are high;
  // valid never waits on ready, and a stalled bin holds all its fields.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // Out-of-range counts collapse to a single mode before the record is stored.
  always_comb begin
    n_eff        = in_num_modes;
    push_illegal = 1'b0;
    if (in_num_modes == '0 || in_num_modes > NW'(MAX_MODES)) begin
      n_eff        = NW'(1);
      push_illegal = 1'b1;
    end
    for (int k = 0; k < MAX_MODES; k++)
      if (NW'(k) < n_eff && mode_illegal(in_modes[k*CHROMA_MODE_W +: CHROMA_MODE_W]))
        push_illegal = 1'b1;
  end

  cu_rec_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({n_eff, in_modes}),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_illegal <= 1'b0;
    else if (push && push_illegal) err_illegal <= 1'b1;
  end

  // ---------------- serialiser FSM ----------------
  ser_state_t       state, state_d;
  logic [NW-1:0]    idx, idx_d;
  logic [NW-1:0]    rec_n, rec_n_d;
  logic [MW-1:0]    rec_modes, rec_modes_d;
  logic             fire;
  logic             cur_is_dm;
  logic             mode_done;
  chroma_mode_rec_t nxt_mode;
  logic             nxt_last;
  logic             bin_valid_d;
  logic             bin_val_d;
  logic             bin_bypass_d;
  logic             bin_last_d;

  assign fire      = bin_valid && bin_ready;
  assign cur_is_dm = mode_is_dm(pick_mode(rec_modes, idx));

  // State register; the bin outputs are registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rec_n      <= '0;
      rec_modes  <= '0;
      bin_valid  <= 1'b0;
      bin_val    <= 1'b0;
      bin_bypass <= 1'b0;
      bin_last   <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      rec_n      <= rec_n_d;
      rec_modes  <= rec_modes_d;
      bin_valid  <= bin_valid_d;
      bin_val    <= bin_val_d;
      bin_bypass <= bin_bypass_d;
      bin_last   <= bin_last_d;
    end
  end

  // Next state. Finishing a mode moves straight to the next mode or the next
  // record on the same edge, so there is no bubble between them.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    load      = 1'b0;
    mode_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = PREFIX;
        end
      end
      PREFIX: if (fire) begin
        if (cur_is_dm) mode_done = 1'b1;
        else           state_d   = SUF1;
      end
      SUF1: if (fire) state_d = SUF0;
      SUF0: if (fire) mode_done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (mode_done) begin
      if (idx != rec_n - NW'(1)) begin
        idx_d   = idx + NW'(1);
        state_d = PREFIX;
      end else if (!fifo_empty) begin
        load    = 1'b1;
        idx_d   = '0;
        state_d = PREFIX;
      end else begin
        state_d = IDLE;
      end
    end
    rec_n_d     = load ? fifo_rdata[RW-1 -: NW] : rec_n;
    rec_modes_d = load ? fifo_rdata[MW-1:0]     : rec_modes;
  end

  // Output decode from the upcoming state, so a stalled bin re-derives itself.
  always_comb begin
    nxt_mode     = decode_mode(pick_mode(rec_modes_d, idx_d));
    nxt_last     = (idx_d == rec_n_d - NW'(1));
    bin_valid_d  = (state_d != IDLE);
    bin_val_d    = 1'b0;
    bin_bypass_d = 1'b0;
    bin_last_d   = 1'b0;
    case (state_d)
      PREFIX: begin
        bin_val_d  = !nxt_mode.is_dm;
        bin_last_d = nxt_mode.is_dm && nxt_last;
      end
      SUF1: begin
        bin_val_d    = nxt_mode.m[1];
        bin_bypass_d = 1'b1;
      end
      SUF0: begin
        bin_val_d    = nxt_mode.m[0];
        bin_bypass_d = 1'b1;
        bin_last_d   = nxt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       bin_count <= '0;
    else if (fire) bin_count <= bin_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_intra_chroma_mode_bin_serializer.sv
// Directed bench for the chroma intra-mode bin serialiser with hand-computed
// bin sequences held in an expected queue.
module tb_intra_chroma_mode_bin_serializer;

  localparam int MAX_MODES  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  // Expected bin encoding {val, bypass, last}.
  localparam logic [2:0] C0  = 3'b000;
  localparam logic [2:0] C1  = 3'b100;
  localparam logic [2:0] B0  = 3'b010;
  localparam logic [2:0] B1  = 3'b110;
  localparam logic [2:0] C0L = 3'b001;
  localparam logic [2:0] B0L = 3'b011;
  localparam logic [2:0] B1L = 3'b111;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_num_modes;
  logic [11:0]      in_modes;
  logic             bin_valid;
  logic             bin_ready;
  logic             bin_val;
  logic             bin_bypass;
  logic             bin_last;
  logic [CNT_W-1:0] bin_count;
  logic             err_illegal;

  logic [2:0] exp_q[$];
  int n_checks;
  int n_err;
  int cyc;
  int hs_n;
  int first_hs;
  int last_hs;

  intra_chroma_mode_bin_serializer #(
    .MAX_MODES  (MAX_MODES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num_modes (in_num_modes),
    .in_modes     (in_modes),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin_val      (bin_val),
    .bin_bypass   (bin_bypass),
    .bin_last     (bin_last),
    .bin_count    (bin_count),
    .err_illegal  (err_illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_rec(input logic [2:0] n, input logic [11:0] modes);
    int t;
    in_num_modes = n;
    in_modes     = modes;
    in_valid     = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("push_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bin_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0 || bin_valid)
      check("drain_timeout", {31'(exp_q.size()), bin_valid}, 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  // Every presented bin must match the queue head; it is retired on handshake.
  always @(negedge clk) begin
    if (!rst && bin_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bin", bin_valid, 1'b0);
      end else begin
        check("bin", {bin_val, bin_bypass, bin_last}, exp_q[0]);
        if (bin_ready) begin
          void'(exp_q.pop_front());
          if (hs_n == 0) first_hs = cyc;
          hs_n++;
          last_hs = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_err = 0; hs_n = 0; first_hs = 0; last_hs = 0;
    rst = 1'b1; in_valid = 1'b0; in_num_modes = '0; in_modes = '0; bin_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_valid", bin_valid, 1'b0);
    check("rst_val", bin_val, 1'b0);
    check("rst_bypass", bin_bypass, 1'b0);
    check("rst_last", bin_last, 1'b0);
    check("rst_count", bin_count, 0);
    check("rst_err", err_illegal, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single DM mode: one ctx bin 0 with last, visible one edge after the push.
    bin_ready = 1'b1;
    exp_q.push_back(C0L);
    push_rec(3'd1, 12'h004);
    check("lat_before", bin_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_after", bin_valid, 1'b1);
    wait_drain();
    check("count_dm", bin_count, 1);

    // Single explicit ANG10.
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B0L);
    push_rec(3'd1, 12'h002);
    wait_drain();
    check("count_ang10", bin_count, 4);

    // Four modes [4,0,3,1]: 10 bins, no gaps.
    hs_n = 0;
    exp_q.push_back(C0);
    exp_q.push_back(C1); exp_q.push_back(B0); exp_q.push_back(B0);
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B1);
    exp_q.push_back(C1); exp_q.push_back(B0); exp_q.push_back(B1L);
    push_rec(3'd4, {3'd1, 3'd3, 3'd0, 3'd4});
    wait_drain();
    check("hs_four", hs_n, 10);
    check("span_four", last_hs - first_hs, 9);
    check("count_four", bin_count, 14);

    // Backpressure on DC: stalled bins hold, count sees handshakes only.
    bin_ready = 1'b0;
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B1L);
    push_rec(3'd1, 12'h003);
    begin
      logic [9:0] pat;
      pat = 10'b1111001001;
      for (int i = 0; i < 10; i++) begin
        bin_ready = pat[i];
        @(posedge clk); #1;
      end
    end
    bin_ready = 1'b1;
    wait_drain();
    check("count_bp", bin_count, 17);

    // FIFO full: the FSM holds P0 stalled while four more records fill the FIFO.
    bin_ready = 1'b0;
    exp_q.push_back(C0L);
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B0L);
    exp_q.push_back(C1); exp_q.push_back(B0); exp_q.push_back(B0); exp_q.push_back(C0L);
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B1L);
    exp_q.push_back(C0L);
    push_rec(3'd1, 12'h004);
    @(posedge clk); #1;
    check("full_pre", in_ready, 1'b1);
    push_rec(3'd1, 12'h002);
    push_rec(3'd2, {6'd0, 3'd4, 3'd0});
    push_rec(3'd1, 12'h003);
    push_rec(3'd1, 12'h004);
    check("full_ready", in_ready, 1'b0);
    in_num_modes = 3'd1; in_modes = 12'h002; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("full_hold", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    hs_n = 0;
    bin_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_pop", in_ready, 1'b1);
    wait_drain();
    check("hs_full", hs_n, 12);
    check("span_full", last_hs - first_hs, 11);
    check("count_full", bin_count, 29);

    // Illegal inputs: mode 6, count 0, count 7.
    check("err_clean", err_illegal, 1'b0);
    exp_q.push_back(C0L);
    push_rec(3'd1, 12'h006);
    check("err_mode", err_illegal, 1'b1);
    wait_drain();
    check("count_ill_mode", bin_count, 30);
    exp_q.push_back(C1); exp_q.push_back(B1); exp_q.push_back(B0L);
    push_rec(3'd0, 12'h002);
    wait_drain();
    check("count_n0", bin_count, 33);
    exp_q.push_back(C0L);
    push_rec(3'd7, 12'h924);
    wait_drain();
    check("count_n7", bin_count, 34);
    check("err_sticky", err_illegal, 1'b1);

    // Reset after two of ANG26's three bins; a queued record must be flushed.
    hs_n = 0;
    exp_q.push_back(C1); exp_q.push_back(B0); exp_q.push_back(B1L);
    exp_q.push_back(C0L);
    push_rec(3'd1, 12'h001);
    push_rec(3'd1, 12'h004);
    begin
      int t;
      t = 0;
      while (hs_n < 2 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("mid_hs", hs_n, 2);
    check("mid_count", bin_count, 36);
    check("mid_valid", bin_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_valid", bin_valid, 1'b0);
    check("arst_count", bin_count, 0);
    check("arst_err", err_illegal, 1'b0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_valid", bin_valid, 1'b0);
    check("post_rst_count", bin_count, 0);
    check("post_rst_last", bin_last, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
